// File: rtl/gfx_pkg.sv
// Shared types for the line-draw command path: FSM states, the queued
// command layout and the colour-cache hit test used by the sequencer.
package gfx_pkg;

    localparam int LINE_CMD_W = 72;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_COLOR,
        ST_LD_X0,
        ST_LD_Y0,
        ST_LD_X1,
        ST_LD_Y1,
        ST_TRIG,
        ST_HOLD,
        ST_WAIT
    } lcs_state_t;

    typedef struct packed {
        logic [31:0] color;
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
    } line_cmd_t;

    // True when the engine already holds this colour, so its load can be skipped.
    function automatic logic color_hit(input logic        cache_vld,
                                       input logic [31:0] cache_color,
                                       input logic [31:0] color);
        return cache_vld && (cache_color == color);
    endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Show-ahead synchronous FIFO for queued line commands. Pointers carry an
// extra wrap bit so full and empty are told apart without a separate flag.
module line_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 72
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers advance on accepted operations; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/line_cmd_sequencer.sv
// Queues complete line-draw commands and replays each one to the line
// engine as colour/x0/y0/x1/y1 strobes followed by a trigger, skipping the
// colour load when the engine already holds that colour.
module line_cmd_sequencer
    import gfx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_color,
    input  logic [9:0]               cmd_x0,
    input  logic [9:0]               cmd_y0,
    input  logic [9:0]               cmd_x1,
    input  logic [9:0]               cmd_y1,
    input  logic                     LE_ready,
    output logic [31:0]              LE_color,
    output logic [9:0]               LE_point,
    output logic                     LE_color_valid,
    output logic                     LE_x0_valid,
    output logic                     LE_y0_valid,
    output logic                     LE_x1_valid,
    output logic                     LE_y1_valid,
    output logic                     LE_trigger,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     busy,
    output logic [15:0]              lines_done
);

    lcs_state_t  state;
    lcs_state_t  state_nxt;
    line_cmd_t   cmd_in;
    line_cmd_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [9:0]  cur_x0;
    logic [9:0]  cur_y0;
    logic [9:0]  cur_x1;
    logic [9:0]  cur_y1;
    logic [31:0] cache_color;
    logic        cache_vld;
    logic [15:0] lines_done_q;

    assign cmd_in     = '{color: cmd_color, x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1};
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign busy       = !fifo_empty || (state != ST_IDLE);
    assign lines_done = lines_done_q;
    assign LE_color   = cache_color;

    line_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LINE_CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (cmd_in),
        .rd_data (head),
        .count   (pending),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state and pop decision; only IDLE and WAIT look at LE_ready.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && LE_ready) begin
                    pop       = 1'b1;
                    state_nxt = color_hit(cache_vld, cache_color, head.color) ? ST_LD_X0 : ST_LD_COLOR;
                end
            end
            ST_LD_COLOR: state_nxt = ST_LD_X0;
            ST_LD_X0:    state_nxt = ST_LD_Y0;
            ST_LD_Y0:    state_nxt = ST_LD_X1;
            ST_LD_X1:    state_nxt = ST_LD_Y1;
            ST_LD_Y1:    state_nxt = ST_TRIG;
            ST_TRIG:     state_nxt = ST_HOLD;
            ST_HOLD:     state_nxt = ST_WAIT;
            ST_WAIT:     if (LE_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Colour cache is loaded on the pop edge so LE_color already carries the
    // new colour during the LD_COLOR strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld   <= 1'b0;
            cache_color <= '0;
        end else if (pop && !color_hit(cache_vld, cache_color, head.color)) begin
            cache_vld   <= 1'b1;
            cache_color <= head.color;
        end
    end

    // Current-command endpoints captured at pop; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (pop) begin
            cur_x0 <= head.x0;
            cur_y0 <= head.y0;
            cur_x1 <= head.x1;
            cur_y1 <= head.y1;
        end
    end

    // Completed-line counter, bumped when the engine reports idle after a trigger.
    always_ff @(posedge clk) begin
        if (rst)                            lines_done_q <= '0;
        else if (state == ST_WAIT && LE_ready) lines_done_q <= lines_done_q + 16'd1;
    end

    // Engine-side outputs decoded purely from state and the current command.
    always_comb begin
        LE_point       = '0;
        LE_color_valid = 1'b0;
        LE_x0_valid    = 1'b0;
        LE_y0_valid    = 1'b0;
        LE_x1_valid    = 1'b0;
        LE_y1_valid    = 1'b0;
        LE_trigger     = 1'b0;
        case (state)
            ST_LD_COLOR: LE_color_valid = 1'b1;
            ST_LD_X0:    begin LE_x0_valid = 1'b1; LE_point = cur_x0; end
            ST_LD_Y0:    begin LE_y0_valid = 1'b1; LE_point = cur_y0; end
            ST_LD_X1:    begin LE_x1_valid = 1'b1; LE_point = cur_x1; end
            ST_LD_Y1:    begin LE_y1_valid = 1'b1; LE_point = cur_y1; end
            ST_TRIG:     LE_trigger = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Testbench for line_cmd_sequencer: scenario tasks drive randomized commands
// and compare the lines seen on the engine port against a queue-based model.
module tb_line_cmd_sequencer;
    import gfx_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_color = '0;
    logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic        LE_ready = 1'b0;
    logic [31:0] LE_color;
    logic [9:0]  LE_point;
    logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
    logic        LE_trigger;
    logic [$clog2(DEPTH):0] pending;
    logic        busy;
    logic [15:0] lines_done;

    line_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_color(cmd_color), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
        .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
        .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger),
        .pending(pending), .busy(busy), .lines_done(lines_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] color_strobe;
        logic [31:0] color_trig;
        logic [9:0]  x0, y0, x1, y1;
        bit          loaded;
        int          trig_cyc;
    } obs_t;

    obs_t      obs_q[$];
    obs_t      cur_obs;
    int        ord = 0;
    int        viol = 0;
    line_cmd_t mq[$];
    logic [31:0] m_cache = '0;
    bit        m_cache_vld = 0;
    logic [15:0] m_done = '0;
    int        trig_at[$];

    // Engine-side monitor: assembles each issued line and flags protocol breaks.
    always @(negedge clk) begin
        if (rst) begin
            ord = 0;
            cur_obs = '{default: 0};
        end else begin
            if ($countones({LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}) > 1) viol++;
            if (!(LE_x0_valid | LE_y0_valid | LE_x1_valid | LE_y1_valid) && LE_point !== 10'd0) viol++;
            if (LE_color_valid) begin if (ord != 0) viol++; cur_obs.loaded = 1; cur_obs.color_strobe = LE_color; end
            if (LE_x0_valid) begin if (ord != 0) viol++; cur_obs.x0 = LE_point; ord = 1; end
            if (LE_y0_valid) begin if (ord != 1) viol++; cur_obs.y0 = LE_point; ord = 2; end
            if (LE_x1_valid) begin if (ord != 2) viol++; cur_obs.x1 = LE_point; ord = 3; end
            if (LE_y1_valid) begin if (ord != 3) viol++; cur_obs.y1 = LE_point; ord = 4; end
            if (LE_trigger) begin
                if (ord != 4) viol++;
                cur_obs.color_trig = LE_color;
                cur_obs.trig_cyc = cyc;
                obs_q.push_back(cur_obs);
                cur_obs = '{default: 0};
                ord = 0;
            end
        end
    end

    function automatic line_cmd_t rand_cmd(input logic [31:0] color);
        line_cmd_t c;
        c.color = color;
        c.x0 = 10'($urandom_range(0, 1023));
        c.y0 = 10'($urandom_range(0, 1023));
        c.x1 = 10'($urandom_range(0, 1023));
        c.y1 = 10'($urandom_range(0, 1023));
        return c;
    endfunction

    function automatic logic [31:0] rand_color();
        logic [31:0] pal [4] = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00123456};
        return pal[$urandom_range(0, 3)];
    endfunction

    // Offer one command for one cycle; starts and ends on a falling edge.
    task automatic push_cmd(input line_cmd_t c, output bit acc, output int pc);
        cmd_valid = 1'b1;
        cmd_color = c.color;
        cmd_x0 = c.x0; cmd_y0 = c.y0; cmd_x1 = c.x1; cmd_y1 = c.y1;
        acc = cmd_ready;
        @(posedge clk);
        #1;
        pc = cyc;
        if (acc) mq.push_back(c);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Compare the next n issued lines against the model queue, in order.
    task automatic check_lines(input int n);
        int waited = 0;
        obs_t o;
        line_cmd_t e;
        bit exp_loaded;
        trig_at.delete();
        while (obs_q.size() < n && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (obs_q.size() < n || mq.size() < n) begin
            tests_failed++;
            $display("FAIL lines_issued: got %0d lines, model has %0d, need %0d", obs_q.size(), mq.size(), n);
            obs_q.delete();
            return;
        end
        for (int i = 0; i < n; i++) begin
            o = obs_q.pop_front();
            e = mq.pop_front();
            exp_loaded = !m_cache_vld || (m_cache != e.color);
            if (exp_loaded) begin m_cache = e.color; m_cache_vld = 1; end
            m_done = m_done + 16'd1;
            trig_at.push_back(o.trig_cyc);
            tests_run++;
            if (o.x0 !== e.x0 || o.y0 !== e.y0 || o.x1 !== e.x1 || o.y1 !== e.y1 ||
                o.color_trig !== e.color || o.loaded !== exp_loaded ||
                (exp_loaded && o.color_strobe !== e.color)) begin
                tests_failed++;
                $display("FAIL line[%0d]: got c=%h ld=%0d (%0d,%0d)->(%0d,%0d) want c=%h ld=%0d (%0d,%0d)->(%0d,%0d)",
                         i, o.color_trig, o.loaded, o.x0, o.y0, o.x1, o.y1,
                         e.color, exp_loaded, e.x0, e.y0, e.x1, e.y1);
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int waited = 0;
        while (busy !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (lines_done !== m_done) begin
            tests_failed++;
            $display("FAIL %s_lines_done: got %h want %h (busy=%b)", nm, lines_done, m_done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || pending !== '0 || busy !== 1'b0 || lines_done !== 16'd0 ||
            LE_color !== 32'd0 || LE_point !== 10'd0 ||
            {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger} !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_values: rdy=%b pend=%0d busy=%b done=%h col=%h pt=%h", cmd_ready, pending, busy, lines_done, LE_color, LE_point);
        end
        rst = 1'b0;
        m_cache_vld = 0; m_done = '0;
    endtask

    task automatic test_single_line();
        bit acc; int pc;
        line_cmd_t c = '{color: 32'h00FF0000, x0: 10'd10, y0: 10'd20, x1: 10'd30, y1: 10'd40};
        LE_ready = 1'b1;
        push_cmd(c, acc, pc);
        check_lines(1);
        tests_run++;
        if (trig_at.size() < 1 || trig_at[0] !== pc + 6) begin
            tests_failed++;
            $display("FAIL single_trig_time: got %0d want %0d", (trig_at.size() > 0) ? trig_at[0] : -1, pc + 6);
        end
        wait_idle("single");
    endtask

    task automatic test_color_cache();
        bit acc; int pc0, pc1;
        push_cmd(rand_cmd(32'h000000FF), acc, pc0);
        push_cmd(rand_cmd(32'h000000FF), acc, pc1);
        check_lines(2);
        tests_run++;
        if (trig_at.size() < 2 || trig_at[0] !== pc0 + 6 || trig_at[1] !== pc0 + 14) begin
            tests_failed++;
            $display("FAIL cache_trig_times: got %0d,%0d want %0d,%0d",
                     (trig_at.size() > 0) ? trig_at[0] : -1, (trig_at.size() > 1) ? trig_at[1] : -1, pc0 + 6, pc0 + 14);
        end
        wait_idle("cache");
    endtask

    task automatic test_fill_to_full();
        bit acc; int pc;
        logic [8:0] acc_bits = '0;
        LE_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_cmd(rand_cmd(rand_color()), acc, pc);
            acc_bits[i] = acc;
            if (i == 7) begin
                tests_run++;
                if (pending !== 4'd8 || cmd_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fill_full_flags: pending=%0d rdy=%b want 8 0", pending, cmd_ready);
                end
            end
        end
        tests_run++;
        if (acc_bits !== 9'b0_1111_1111) begin
            tests_failed++;
            $display("FAIL fill_accept: got %b want 011111111", acc_bits);
        end
        LE_ready = 1'b1;
        check_lines(8);
        wait_idle("fill");
    endtask

    task automatic test_stall();
        bit acc; int pc; int c0; int bad = 0; int waited = 0;
        logic [31:0] col = rand_color();
        LE_ready = 1'b1;
        push_cmd(rand_cmd(col), acc, pc);
        push_cmd(rand_cmd(col), acc, pc);
        while (LE_trigger !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        LE_ready = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if ({LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger} !== 6'd0 ||
                pending !== 4'd1 || busy !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0 || waited >= 100) begin
            tests_failed++;
            $display("FAIL stall_quiet: got %0d bad cycles (trigger wait %0d) want 0", bad, waited);
        end
        c0 = cyc;
        LE_ready = 1'b1;
        check_lines(2);
        tests_run++;
        if (trig_at.size() < 2 || trig_at[1] !== c0 + 6) begin
            tests_failed++;
            $display("FAIL stall_resume_time: got %0d want %0d", (trig_at.size() > 1) ? trig_at[1] : -1, c0 + 6);
        end
        wait_idle("stall");
    endtask

    task automatic test_reset_mid_line();
        bit acc; int pc; int waited = 0;
        logic [31:0] col = 32'h00ABCDEF;
        LE_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd(col), acc, pc);
        while (LE_y0_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (waited >= 100 || pending !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || LE_color !== 32'd0 ||
            lines_done !== 16'd0 ||
            {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger} !== 6'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: pend=%0d busy=%b rdy=%b col=%h done=%h (wait %0d)", pending, busy, cmd_ready, LE_color, lines_done, waited);
        end
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); obs_q.delete();
        m_cache_vld = 0; m_done = '0;
        push_cmd(rand_cmd(col), acc, pc);
        check_lines(1);
        tests_run++;
        if (trig_at.size() < 1 || trig_at[0] !== pc + 6) begin
            tests_failed++;
            $display("FAIL midreset_reload_time: got %0d want %0d", (trig_at.size() > 0) ? trig_at[0] : -1, pc + 6);
        end
        wait_idle("midreset");
    endtask

    task automatic test_push_pop_full();
        bit acc; int pc;
        LE_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_cmd(rand_cmd(rand_color()), acc, pc);
        LE_ready = 1'b1;
        push_cmd(rand_cmd(rand_color()), acc, pc);
        tests_run++;
        if (acc !== 1'b0 || pending !== 4'(DEPTH - 1) || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pushpop: acc=%b pending=%0d rdy=%b want 0 %0d 1", acc, pending, cmd_ready, DEPTH - 1);
        end
        check_lines(DEPTH);
        wait_idle("fullpp");
    endtask

    task automatic test_counter_wrap();
        bit acc; int pc;
        force dut.lines_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.lines_done_q;
        m_done = 16'hFFFF;
        @(negedge clk);
        tests_run++;
        if (lines_done !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preload: got %h want ffff", lines_done);
        end
        LE_ready = 1'b1;
        push_cmd(rand_cmd(rand_color()), acc, pc);
        check_lines(1);
        wait_idle("wrap");
        tests_run++;
        if (lines_done !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap_zero: got %h want 0000", lines_done);
        end
    endtask

    task automatic test_protocol_summary();
        tests_run++;
        if (viol != 0 || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL protocol: got %0d violations, %0d unexpected lines, want 0 0", viol, obs_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_line();
        test_color_cache();
        test_fill_to_full();
        test_stall();
        test_reset_mid_line();
        test_push_pop_full();
        test_counter_wrap();
        test_protocol_summary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/line_cmd_sequencer.md
# line_cmd_sequencer

Buffers complete line-draw commands (color plus two endpoints) posted by the CPU's memory-mapped I/O logic and feeds them one at a time to the line engine. It uses the engine's per-field valid-strobe and trigger protocol and waits for the engine to return to idle before issuing the next line. It sits between the MMIO decode and the line engine, so software can queue lines without polling `LE_ready`.

## Interface

- Reset `rst`: synchronous, active-high. Clock `clk`.

Parameters:
- `DEPTH`, default 8: command FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: FIFO can accept a command.
- `cmd_color`, in, 32: `{8'h00, R, G, B}`.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1`, in, 10 each: endpoints.
- `LE_ready`, in, 1: the line engine is idle.
- `LE_color`, out, 32: color to the engine.
- `LE_point`, out, 10: coordinate to the engine.
- `LE_color_valid`, `LE_x0_valid`, `LE_y0_valid`, `LE_x1_valid`, `LE_y1_valid`, out, 1 each: field strobes.
- `LE_trigger`, out, 1: start drawing.
- `pending`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `busy`, out, 1: FIFO non-empty or FSM not in IDLE.
- `lines_done`, out, 16: completed-line counter; wraps from 0xFFFF to 0.

## Operation

- Push occurs on `cmd_valid && cmd_ready`. `cmd_ready = (pending != DEPTH)` and depends on occupancy only; there is no same-cycle bypass when full.
- Coordinates pass through unchanged. Out-of-screen values and zero-length lines are still issued.
- FSM states: IDLE, LD_COLOR, LD_X0, LD_Y0, LD_X1, LD_Y1, TRIG, HOLD, WAIT.
- **IDLE:** if the FIFO is non-empty and `LE_ready`=1, pop the head into the current-command register.
  - Go to LD_COLOR if the color cache is invalid or the head color differs from the cached color.
  - Otherwise go to LD_X0.
- **LD_COLOR:** assert `LE_color_valid`; load the cache with the color and mark it valid; go to LD_X0.
- **LD_X0, LD_Y0, LD_X1, LD_Y1:** drive `LE_point` with the matching field and assert the matching strobe, one cycle each, in that order.
- **TRIG:** assert `LE_trigger` for one cycle; go to HOLD.
- **HOLD:** wait one cycle, ignoring `LE_ready`. This covers the engine's registered state update after the trigger.
- **WAIT:** stay until `LE_ready`=1. On exit, increment `lines_done` and go to IDLE.
- Load states do not sample `LE_ready`.
- All `LE_*` outputs are decoded from the state and current-command registers only. There is no combinational path from any input.
- `LE_color` always drives the cached color. `LE_point` is 0 outside the LD_X*/LD_Y* states.
- At most one strobe or trigger is high in any cycle.

## Timing

- Reset values: FSM in IDLE, FIFO empty, `cmd_ready`=1, `pending`=0, `busy`=0, `lines_done`=0, color cache invalid, all strobes and `LE_trigger` 0, `LE_point`=0, `LE_color`=0.
- Reset mid-operation:
  - the current line is abandoned and queued commands are discarded;
  - on the cycle after reset, all outputs hold their reset values;
  - the line engine shares `rst`.
- Push at edge t gives `pending`=1 after t. The pop decision is made in the cycle after t, so the first strobe appears in the second cycle after edge t.
- Cycles from pop edge to the `LE_trigger` cycle: 6 with a color load, 5 without.
- Minimum issue interval, with `LE_ready` returning immediately: 9 cycles (color reloaded) or 8 cycles (color cached).
- Simultaneous push and pop updates `pending` by net 0. When full, `cmd_ready` stays 0 during the pop cycle and rises the cycle after.
- `lines_done` updates on the WAIT→IDLE edge.

## Structure

- Package `gfx_pkg` holds:
  - state enum `lcs_state_t`;
  - packed struct `line_cmd_t {color[31:0], x0, y0, x1, y1}`, 72 bits;
  - constant `LINE_CMD_W` = 72.
- Sub-module `line_cmd_fifo`: synchronous FIFO of `line_cmd_t`, parameters `DEPTH` and `WIDTH`.
  - Pointers carry one extra wrap bit.
  - Ports: `count`, `full`, `empty`, `push`, `pop`.
  - Read data is valid while not empty (show-ahead).
- The top level contains the FSM, color cache and counter.

## Test plan

- **Single line:** push color 0x00FF0000, (10,20)→(30,40) with `LE_ready`=1.
  - Strobes appear in the order color, x0=10, y0=20, x1=30, y1=40, then trigger.
  - Trigger occurs 6 cycles after the pop.
  - `lines_done`=1 after `LE_ready` returns.
- **Color cache:** push two lines, both with color 0x000000FF.
  - `LE_color_valid` pulses only for the first line.
  - The second line's trigger comes 5 cycles after its pop.
- **Fill to full:** push 9 commands with DEPTH=8 while `LE_ready`=0.
  - `cmd_ready` drops after the 8th push and `pending`=8.
  - Raise `LE_ready`: all 8 lines issue in FIFO order and `lines_done`=8.
- **Engine stall:** hold `LE_ready` low for 50 cycles after the trigger.
  - The FSM stays in WAIT and no strobes are issued.
  - The next line's pop follows `LE_ready` going high.
- **Reset mid-line:** assert `rst` during LD_Y0 with 3 commands queued.
  - Next cycle: `pending`=0, `busy`=0, no strobes.
  - After reset the color cache is invalid, so the next line reloads its color.
- **Push/pop at full:** push on the same edge as a pop while `pending`=DEPTH.
  - The push is rejected and `pending`=DEPTH−1 afterward.
  - `lines_done` wraps from 0xFFFF to 0 when preloaded by force.
